// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, the register-zero constant and the ID/EX control bundle
// used by the decode-to-execute operand stage.
package id_ex_operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_ADDR = '0;

  // Control fields carried from ID into EX alongside the operands.
  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } idex_ctrl_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Priority operand select for one source register: hard zero, then the
// youngest producer (EX), then MEM, then WB, then the register file.
module operand_bypass_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [AW-1:0]   src,
  input  logic            ex_fwd_en,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_fwd_en,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_fwd_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] rf_data,
  output logic [XLEN-1:0] operand
);

  logic src_is_zero;

  // Register zero short-circuits every hit, so a rd of 0 can never bypass.
  assign src_is_zero = ZERO_REG && (src == ZERO_ADDR);

  // Youngest matching producer wins; WB covers the write landing this cycle.
  always_comb begin
    // NOTE: assign a default first in every always_comb so no path leaves the output unassigned and infers a latch.
    operand = rf_data;
    if (src_is_zero) begin
      operand = '0;
    end else if (ex_fwd_en && (ex_rd == src)) begin
      operand = ex_data;
    end else if (mem_fwd_en && (mem_rd == src)) begin
      operand = mem_data;
    end else if (wb_fwd_en && (wb_rd == src)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: drives register-file read addresses, resolves operands by
// bypassing or a one-cycle load-use bubble, and holds the ID/EX register.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic [XLEN-1:0]  id_imm,
  output logic [AW-1:0]    rf_readdr1,
  output logic [AW-1:0]    rf_readdr2,
  input  logic [XLEN-1:0]  rf_readata1,
  input  logic [XLEN-1:0]  rf_readata2,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_valid,
  input  logic             wb_regwrite,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [AW-1:0]    ex_rd,
  output logic [AW-1:0]    ex_rs1,
  output logic [AW-1:0]    ex_rs2,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [CNT_W-1:0] bubble_count
);

  idex_ctrl_t       ctrl_q, ctrl_d;
  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic            ex_fwd_en, mem_fwd_en, wb_fwd_en;
  logic [XLEN-1:0] op1_res, op2_res;
  logic            load_rd_live, lu_rs1, lu_rs2, load_use;

  assign rf_readdr1 = id_rs1;
  assign rf_readdr2 = id_rs2;

  // A load in EX has no data yet, so it is never an EX bypass source.
  assign ex_fwd_en  = ctrl_q.valid & ctrl_q.regwrite & ~ctrl_q.memread;
  assign mem_fwd_en = mem_valid & mem_regwrite;
  assign wb_fwd_en  = wb_valid & wb_regwrite;

  operand_bypass_mux #(.ZERO_REG(ZERO_REG)) u_bypass_rs1 (
    .src        (id_rs1),
    .ex_fwd_en  (ex_fwd_en),
    .ex_rd      (ctrl_q.rd),
    .ex_data    (ex_alu_result),
    .mem_fwd_en (mem_fwd_en),
    .mem_rd     (mem_rd),
    .mem_data   (mem_result),
    .wb_fwd_en  (wb_fwd_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rf_data    (rf_readata1),
    .operand    (op1_res)
  );

  operand_bypass_mux #(.ZERO_REG(ZERO_REG)) u_bypass_rs2 (
    .src        (id_rs2),
    .ex_fwd_en  (ex_fwd_en),
    .ex_rd      (ctrl_q.rd),
    .ex_data    (ex_alu_result),
    .mem_fwd_en (mem_fwd_en),
    .mem_rd     (mem_rd),
    .mem_data   (mem_result),
    .wb_fwd_en  (wb_fwd_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rf_data    (rf_readata2),
    .operand    (op2_res)
  );

  // A load targeting hard-wired zero produces nothing worth waiting for.
  assign load_rd_live = !(ZERO_REG && (ctrl_q.rd == ZERO_ADDR));
  assign lu_rs1       = id_use_rs1 & (ctrl_q.rd == id_rs1);
  assign lu_rs2       = id_use_rs2 & (ctrl_q.rd == id_rs2);
  assign load_use     = id_valid & ctrl_q.valid & ctrl_q.memread & load_rd_live
                        & (lu_rs1 | lu_rs2);

  assign stall = ~rst & ~flush & (hold | load_use);

  // Next ID/EX contents: hold, then flush, then load-use bubble, then advance.
  always_comb begin
    ctrl_d   = ctrl_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    imm_d    = imm_q;
    bubble_d = bubble_q;
    if (hold) begin
      // Everything keeps its value, including the bubble counter.
    end else if (flush) begin
      ctrl_d = '0;
      op1_d  = '0;
      op2_d  = '0;
      imm_d  = '0;
    end else if (load_use) begin
      ctrl_d = '0;
      op1_d  = '0;
      op2_d  = '0;
      imm_d  = '0;
      if (bubble_q != '1) begin
        bubble_d = bubble_q + 1'b1;
      end
    end else begin
      ctrl_d.valid    = id_valid;
      ctrl_d.regwrite = id_valid & id_regwrite;
      ctrl_d.memread  = id_valid & id_memread;
      ctrl_d.memwrite = id_valid & id_memwrite;
      ctrl_d.rd       = id_rd;
      ctrl_d.rs1      = id_rs1;
      ctrl_d.rs2      = id_rs2;
      op1_d           = op1_res;
      op2_d           = op2_res;
      imm_d           = id_imm;
    end
  end

  // ID/EX register and bubble counter with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ctrl_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      imm_q    <= '0;
      bubble_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      imm_q    <= imm_d;
      bubble_q <= bubble_d;
    end
  end

  assign ex_valid     = ctrl_q.valid;
  assign ex_regwrite  = ctrl_q.regwrite;
  assign ex_memread   = ctrl_q.memread;
  assign ex_memwrite  = ctrl_q.memwrite;
  assign ex_rd        = ctrl_q.rd;
  assign ex_rs1       = ctrl_q.rs1;
  assign ex_rs2       = ctrl_q.rs2;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_imm       = imm_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, bypass priority,
// WB same-cycle bypass, load-use bubble, register zero, counter saturation,
// hold/flush interaction and reset during a stall.
module tb_id_ex_operand_stage;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid;
  logic [4:0]          id_rs1, id_rs2, id_rd;
  logic                id_use_rs1, id_use_rs2;
  logic                id_regwrite, id_memread, id_memwrite;
  logic [31:0]         id_imm;
  logic [4:0]          rf_readdr1, rf_readdr2;
  logic [31:0]         rf_readata1, rf_readata2;
  logic [31:0]         ex_alu_result;
  logic                mem_valid, mem_regwrite;
  logic [4:0]          mem_rd;
  logic [31:0]         mem_result;
  logic                wb_valid, wb_regwrite;
  logic [4:0]          wb_rd;
  logic [31:0]         wb_data;
  logic                flush, hold;
  logic                stall;
  logic                ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]          ex_rd, ex_rs1, ex_rs2;
  logic [31:0]         ex_op1, ex_op2, ex_imm;
  logic [TB_CNT_W-1:0] bubble_count;

  int checks   = 0;
  int failures = 0;

  id_ex_operand_stage #(.ZERO_REG(1'b1), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_memwrite  (id_memwrite),
    .id_imm       (id_imm),
    .rf_readdr1   (rf_readdr1),
    .rf_readdr2   (rf_readdr2),
    .rf_readata1  (rf_readata1),
    .rf_readata2  (rf_readata2),
    .ex_alu_result(ex_alu_result),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .hold         (hold),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_memwrite  (ex_memwrite),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_imm       (ex_imm),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_imm = 0;
    rf_readata1 = 0; rf_readata2 = 0; ex_alu_result = 0;
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_valid = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    flush = 0; hold = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd6;
    id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_imm = 32'hCAFE;
    rf_readata1 = 32'h1111; rf_readata2 = 32'h2222; hold = 1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    step();
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    checks++; if ({ex_regwrite, ex_memread, ex_memwrite} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {ex_regwrite, ex_memread, ex_memwrite}); end
    checks++; if ({ex_rd, ex_rs1, ex_rs2} !== 15'd0) begin failures++; $display("FAIL reset_regnums got=%h exp=0", {ex_rd, ex_rs1, ex_rs2}); end
    checks++; if ({ex_op1, ex_op2, ex_imm} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {ex_op1, ex_op2, ex_imm}); end
    checks++; if (bubble_count !== '0) begin failures++; $display("FAIL reset_bubble got=%0d exp=0", bubble_count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_late got=%b exp=0", stall); end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_ex_priority();
    // Producer x3 enters EX.
    idle_inputs();
    id_valid = 1; id_rd = 5'd3; id_regwrite = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_imm = 32'h10;
    #1;
    checks++; if (rf_readdr1 !== 5'd1 || rf_readdr2 !== 5'd2) begin failures++; $display("FAIL rf_addr got=%0d/%0d exp=1/2", rf_readdr1, rf_readdr2); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_regwrite !== 1'b1) begin failures++; $display("FAIL latency got=v%b rd%0d rw%b exp=v1 rd3 rw1", ex_valid, ex_rd, ex_regwrite); end
    // EX, MEM and WB all hit x3: EX wins.
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd3; id_use_rs1 = 1; id_rd = 5'd4; id_regwrite = 1; id_imm = 32'h20;
    rf_readata1 = 32'h11; ex_alu_result = 32'h22;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5'd3; mem_result = 32'h33;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'h44;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ex_hit_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_op1 !== 32'h22) begin failures++; $display("FAIL ex_hit_op1 got=%h exp=00000022", ex_op1); end
    // EX now holds x4, so MEM is the youngest x3 producer.
    id_rd = 5'd6; id_imm = 32'h30;
    step();
    checks++; if (ex_op1 !== 32'h33) begin failures++; $display("FAIL mem_hit_op1 got=%h exp=00000033", ex_op1); end
    checks++; if (ex_imm !== 32'h30) begin failures++; $display("FAIL imm_load got=%h exp=00000030", ex_imm); end
  endtask

  task automatic test_wb_bypass();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd9; id_rs2 = 5'd5; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 5'd8; id_regwrite = 1;
    rf_readata1 = 32'h99; rf_readata2 = 32'h0;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd5; wb_data = 32'hABCD;
    step();
    checks++; if (ex_op2 !== 32'hABCD) begin failures++; $display("FAIL wb_hit_op2 got=%h exp=0000abcd", ex_op2); end
    checks++; if (ex_op1 !== 32'h99) begin failures++; $display("FAIL rf_op1 got=%h exp=00000099", ex_op1); end
  endtask

  task automatic test_load_use();
    // Load to x7 enters EX (EX currently holds non-load x8).
    idle_inputs();
    id_valid = 1; id_rd = 5'd7; id_regwrite = 1; id_memread = 1; id_rs1 = 5'd1;
    step();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd7; id_use_rs1 = 1; id_rd = 5'd9; id_regwrite = 1;
    rf_readata1 = 32'h1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || {ex_regwrite, ex_memread, ex_memwrite} !== 3'b000) begin failures++; $display("FAIL lu_bubble got=v%b ctrl%b exp=v0 ctrl000", ex_valid, {ex_regwrite, ex_memread, ex_memwrite}); end
    checks++; if (bubble_count !== 4'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", bubble_count); end
    // Load has moved to MEM: no stall, value comes from mem_result.
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5'd7; mem_result = 32'h777;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", stall); end
    step();
    checks++; if (ex_op1 !== 32'h777 || ex_valid !== 1'b1 || ex_rd !== 5'd9) begin failures++; $display("FAIL lu_mem_bypass got=op%h v%b rd%0d exp=op00000777 v1 rd9", ex_op1, ex_valid, ex_rd); end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    id_valid = 1; id_rd = 5'd0; id_regwrite = 1; id_rs1 = 5'd1;
    step();
    // Non-load x0 producer in EX; also WB writing x0.
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd0; id_use_rs1 = 1; id_rd = 5'd0; id_regwrite = 1; id_memread = 1;
    ex_alu_result = 32'h55; rf_readata1 = 32'h66;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 5'd0; wb_data = 32'h77;
    step();
    checks++; if (ex_op1 !== 32'h0) begin failures++; $display("FAIL zero_op1 got=%h exp=00000000", ex_op1); end
    // Load to x0 now in EX: no load-use stall.
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd0; id_use_rs1 = 1; id_rd = 5'd1; id_regwrite = 1;
    ex_alu_result = 32'h55; rf_readata1 = 32'h66;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_no_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h0 || ex_rd !== 5'd1) begin failures++; $display("FAIL zero_pass got=v%b op%h rd%0d exp=v1 op0 rd1", ex_valid, ex_op1, ex_rd); end
  endtask

  task automatic test_saturation_and_hold();
    // Self-dependent load x7 <- [x7]: passes, then bubbles, alternating.
    // 40 cycles add 20 bubbles to the existing 1, well past 2**4+3.
    idle_inputs();
    id_valid = 1; id_rd = 5'd7; id_regwrite = 1; id_memread = 1; id_rs1 = 5'd7; id_use_rs1 = 1;
    for (int i = 0; i < 40; i++) step();
    checks++; if (bubble_count !== 4'hF) begin failures++; $display("FAIL bubble_sat got=%0d exp=15", bubble_count); end
    // Last cycle was a bubble, so EX is empty: load a known instruction.
    idle_inputs();
    id_valid = 1; id_rd = 5'd10; id_regwrite = 1; id_rs1 = 5'd2; id_rs2 = 5'd3;
    id_use_rs1 = 1; id_use_rs2 = 1; id_imm = 32'h1234;
    rf_readata1 = 32'hA1; rf_readata2 = 32'hA2;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_op1 !== 32'hA1 || ex_op2 !== 32'hA2 || ex_imm !== 32'h1234) begin failures++; $display("FAIL known_load got=v%b rd%0d op1%h op2%h imm%h", ex_valid, ex_rd, ex_op1, ex_op2, ex_imm); end
    // Hold with a different valid ID instruction.
    id_rd = 5'd12; id_imm = 32'hDEAD; rf_readata1 = 32'hB1; rf_readata2 = 32'hB2; hold = 1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall got=%b exp=1", stall); end
    step();
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_op1 !== 32'hA1 || ex_op2 !== 32'hA2 || ex_imm !== 32'h1234 || ex_regwrite !== 1'b1) begin failures++; $display("FAIL hold_keep got=v%b rd%0d op1%h op2%h imm%h", ex_valid, ex_rd, ex_op1, ex_op2, ex_imm); end
    checks++; if (bubble_count !== 4'hF) begin failures++; $display("FAIL hold_sat got=%0d exp=15", bubble_count); end
    // Flush with hold: hold wins, stall is suppressed by the flush.
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_hold_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin failures++; $display("FAIL flush_hold_keep got=v%b rd%0d exp=v1 rd10", ex_valid, ex_rd); end
    // Flush alone kills the slot.
    hold = 0;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin failures++; $display("FAIL flush_kill got=v%b rw%b exp=v0 rw0", ex_valid, ex_regwrite); end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    id_valid = 1; id_rd = 5'd7; id_regwrite = 1; id_memread = 1;
    step();
    idle_inputs();
    id_valid = 1; id_rs2 = 5'd7; id_use_rs2 = 1; id_rd = 5'd2; id_regwrite = 1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rs2_lu_stall got=%b exp=1", stall); end
    rst = 1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_drops_stall got=%b exp=0", stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || bubble_count !== '0) begin failures++; $display("FAIL rst_mid_stall got=v%b mr%b cnt%0d exp=v0 mr0 cnt0", ex_valid, ex_memread, bubble_count); end
    rst = 0;
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_ex_priority();
    test_wb_bypass();
    test_load_use();
    test_zero_reg();
    test_saturation_and_hold();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
